// File: rtl/pipe_pkg.sv
// Shared types and defaults for the IF/ID skid-buffered pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_slot.sv
// One payload register {inst, pc} with a valid bit, load and clear-to-NOP.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          INST_W   = 32,
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o
);

    localparam logic [INST_W-1:0] NOP_FIT = INST_W'(NOP_INST);

    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_q;

    // Clear wins over load; pc is left alone so ID still sees the last next-PC.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_FIT;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_FIT;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID stage with a 2-entry skid buffer, registered in_ready, flush and a
// saturating stall counter. All state advances on the falling clock edge.
module ifid_skid_stage
    import pipe_pkg::*;
#(
    parameter int          INST_W   = 32,
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q;

    logic              accept, pop;
    logic              main_load, main_clr, skid_load, skid_clr;
    logic              skid_valid;
    logic [INST_W-1:0] skid_inst, main_inst_d;
    logic [PC_W-1:0]   skid_pc, main_pc_d;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    // The main slot refills from the skid whenever the skid holds the older entry.
    assign main_inst_d = skid_valid ? skid_inst : in_inst;
    assign main_pc_d   = skid_valid ? skid_pc   : in_pc;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            if (out_valid && !out_ready && !flush && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    pipe_slot #(.INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP_INST)) u_main (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .load_i  (main_load),
        .clear_i (main_clr),
        .inst_i  (main_inst_d),
        .pc_i    (main_pc_d),
        .valid_o (out_valid),
        .inst_o  (out_inst),
        .pc_o    (out_pc)
    );

    pipe_slot #(.INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP_INST)) u_skid (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .inst_i  (in_inst),
        .pc_i    (in_pc),
        .valid_o (skid_valid),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc)
    );

    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Scoreboard bench: stimulus queues expected entries, a posedge monitor pops them.
module tb_ifid_skid_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [15:0] stall_cnt;

    logic        in_valid2, in_ready2, out_valid2;
    logic [31:0] in_inst2, in_pc2, out_inst2, out_pc2;
    logic [3:0]  stall_cnt2;

    item_t exp_q[$];
    item_t mon_e;
    int    checks = 0;
    int    failures = 0;
    int    pops = 0;

    always #5 Clk = ~Clk;

    ifid_skid_stage #(.INST_W(32), .PC_W(32), .NOP_INST(32'h0000_0000), .CNT_W(16)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt)
    );

    ifid_skid_stage #(.INST_W(32), .PC_W(32), .NOP_INST(32'h0000_0000), .CNT_W(4)) dut_sat (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_inst   (in_inst2),
        .in_pc     (in_pc2),
        .flush     (1'b0),
        .out_valid (out_valid2),
        .out_ready (1'b0),
        .out_inst  (out_inst2),
        .out_pc    (out_pc2),
        .stall_cnt (stall_cnt2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        item_t it;
        drive(1'b1, inst, pc, ordy, 1'b0);
        it.inst = inst;
        it.pc   = pc;
        exp_q.push_back(it);
    endtask

    // Mid-cycle: an entry visible with out_ready high is consumed at the next negedge.
    always @(posedge Clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got inst %0h pc %0h expected none", out_inst, out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_inst", {32'h0, out_inst}, {32'h0, mon_e.inst});
                check("pop_pc", {32'h0, out_pc}, {32'h0, mon_e.pc});
                pops++;
                $display("pop inst=%08h pc=%08h", out_inst, out_pc);
            end
        end else if (!out_valid) begin
            check("idle_nop", {32'h0, out_inst}, 64'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        in_valid2 = 1'b0;
        in_inst2  = 32'h0000_ABCD;
        in_pc2    = 32'h0000_0010;
        #2 Rst_n = 1'b0;
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_out_inst", {32'h0, out_inst}, 64'h0);
        check("rst_out_pc", {32'h0, out_pc}, 64'h0);
        check("rst_stall", {48'h0, stall_cnt}, 64'h0);
        #4 Rst_n = 1'b1;
        tick;
        check("idle_out_valid", {63'h0, out_valid}, 64'h0);
        check("idle_in_ready", {63'h0, in_ready}, 64'h1);

        // Streaming
        offer(32'h2008_0005, 32'h4, 1'b1);
        tick;
        check("s1_valid", {63'h0, out_valid}, 64'h1);
        check("s1_inst", {32'h0, out_inst}, 64'h2008_0005);
        check("s1_in_ready", {63'h0, in_ready}, 64'h1);
        offer(32'h200A_0003, 32'h8, 1'b1);
        tick;
        check("s2_valid", {63'h0, out_valid}, 64'h1);
        check("s2_inst", {32'h0, out_inst}, 64'h200A_0003);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick;
        check("s3_valid", {63'h0, out_valid}, 64'h0);
        check("s3_pc_hold", {32'h0, out_pc}, 64'h8);
        check("s3_stall", {48'h0, stall_cnt}, 64'h0);

        // Back-pressure
        offer(32'h1111_1111, 32'h100, 1'b0);
        tick;
        check("bp1_stall", {48'h0, stall_cnt}, 64'h0);
        check("bp1_in_ready", {63'h0, in_ready}, 64'h1);
        offer(32'h2222_2222, 32'h104, 1'b0);
        tick;
        check("bp2_in_ready", {63'h0, in_ready}, 64'h0);
        check("bp2_stall", {48'h0, stall_cnt}, 64'h1);
        check("bp2_inst", {32'h0, out_inst}, 64'h1111_1111);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check("bp3_stall", {48'h0, stall_cnt}, 64'h2);
        check("bp3_in_ready", {63'h0, in_ready}, 64'h0);
        check("bp3_inst", {32'h0, out_inst}, 64'h1111_1111);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick;
        check("bp4_inst", {32'h0, out_inst}, 64'h2222_2222);
        check("bp4_in_ready", {63'h0, in_ready}, 64'h1);
        check("bp4_stall", {48'h0, stall_cnt}, 64'h2);
        tick;
        check("bp5_valid", {63'h0, out_valid}, 64'h0);

        // Flush in TWO with a simultaneous offer
        offer(32'h4444_4444, 32'h200, 1'b0);
        tick;
        offer(32'h5555_5555, 32'h204, 1'b0);
        tick;
        check("fl_pre_in_ready", {63'h0, in_ready}, 64'h0);
        check("fl_pre_stall", {48'h0, stall_cnt}, 64'h3);
        drive(1'b1, 32'hCCCC_CCCC, 32'h300, 1'b0, 1'b1);
        exp_q.delete();
        tick;
        check("fl_valid", {63'h0, out_valid}, 64'h0);
        check("fl_inst", {32'h0, out_inst}, 64'h0);
        check("fl_in_ready", {63'h0, in_ready}, 64'h1);
        check("fl_pc_hold", {32'h0, out_pc}, 64'h200);
        check("fl_stall", {48'h0, stall_cnt}, 64'h3);
        offer(32'h3333_3333, 32'h400, 1'b1);
        tick;
        check("fl_d_inst", {32'h0, out_inst}, 64'h3333_3333);
        check("fl_d_valid", {63'h0, out_valid}, 64'h1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick;
        check("fl_d_done", {63'h0, out_valid}, 64'h0);

        // Async reset mid-stream while in TWO
        drive(1'b1, 32'h6666_6666, 32'h500, 1'b0, 1'b0);
        tick;
        drive(1'b1, 32'h7777_7777, 32'h504, 1'b0, 1'b0);
        tick;
        check("ar_pre_in_ready", {63'h0, in_ready}, 64'h0);
        check("ar_pre_inst", {32'h0, out_inst}, 64'h6666_6666);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 Rst_n = 1'b0;
        #1;
        check("ar_valid", {63'h0, out_valid}, 64'h0);
        check("ar_in_ready", {63'h0, in_ready}, 64'h1);
        check("ar_inst", {32'h0, out_inst}, 64'h0);
        check("ar_pc", {32'h0, out_pc}, 64'h0);
        check("ar_stall", {48'h0, stall_cnt}, 64'h0);
        #1 Rst_n = 1'b1;
        tick;
        check("ar_idle_valid", {63'h0, out_valid}, 64'h0);
        check("ar_idle_in_ready", {63'h0, in_ready}, 64'h1);

        // Saturation on the 4-bit counter instance
        in_valid2 = 1'b1;
        tick;
        in_valid2 = 1'b0;
        check("sat_valid", {63'h0, out_valid2}, 64'h1);
        check("sat_cnt0", {60'h0, stall_cnt2}, 64'h0);
        repeat (5) tick;
        check("sat_cnt5", {60'h0, stall_cnt2}, 64'h5);
        repeat (15) tick;
        check("sat_cnt20", {60'h0, stall_cnt2}, 64'hF);
        repeat (3) tick;
        check("sat_hold", {60'h0, stall_cnt2}, 64'hF);

        check("pop_count", 64'(pops), 64'd5);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
